metadata_arbiter: RTL and testbench

Round-robin fetch scheduler between the per-string note channels of the scoring block and the single-port metadata memory filled by the loader. Each channel uses a 4-phase request/available handshake. The block fetches that channel's next 16-bit metadata word from its own region of memory into a per-channel slot of `metadata_link`, then raises `metadata_available`. It serialises all channels onto one memory read port, with at most one read in flight.

---
 rtl/metadata_arbiter_if.sv | 33 +++
 rtl/metadata_arbiter.sv | 138 +++++++++++++
 tb/tb_metadata_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/metadata_arbiter_if.sv
// Channel handshake and metadata memory read port shared by the fetch scheduler.
// The master side is the arbiter; the slave side is the scoring block plus memory.
interface metadata_arbiter_if #(
   parameter int unsigned N_CH   = 37,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PTR_W  = 6,
   parameter int unsigned CH_W   = 6
);
   logic [N_CH-1:0]        metadata_request;
   logic [N_CH-1:0]        metadata_available;
   logic [N_CH*DATA_W-1:0] metadata_link;
   logic                   mem_rd;
   logic [CH_W+PTR_W-1:0]  mem_addr;
   logic [DATA_W-1:0]      mem_rdata;

   modport master (
      input  metadata_request,
      input  mem_rdata,
      output metadata_available,
      output metadata_link,
      output mem_rd,
      output mem_addr
   );

   modport slave (
      output metadata_request,
      output mem_rdata,
      input  metadata_available,
      input  metadata_link,
      input  mem_rd,
      input  mem_addr
   );
endinterface

// File: rtl/metadata_arbiter.sv
// Round-robin fetch scheduler: serialises per-channel metadata fetches onto one
// single-port memory read port, one read in flight, 4-phase request/available handshake.
module metadata_arbiter #(
   parameter int unsigned N_CH   = 37,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PTR_W  = 6,
   parameter int unsigned CH_W   = 6,
   parameter int unsigned RD_LAT = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                pause,
   input  logic                restart,
   output logic                busy,
   metadata_arbiter_if.master  bus
);
   localparam int unsigned AW = CH_W + PTR_W;
   localparam int unsigned CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

   state_e                         state_q, state_d;
   logic [CH_W-1:0]                grant_q, grant_d;
   logic [CH_W-1:0]                last_q, last_d;
   logic [CW-1:0]                  cnt_q, cnt_d;
   logic [N_CH-1:0][PTR_W-1:0]     ptr_q, ptr_d;
   logic [N_CH-1:0][DATA_W-1:0]    link_q, link_d;
   logic [N_CH-1:0]                avail_q, avail_d;
   logic                           mem_rd_q, mem_rd_d;
   logic [AW-1:0]                  mem_addr_q, mem_addr_d;
   logic                           busy_q, busy_d;

   logic [N_CH-1:0]                elig;
   logic                           pick_vld;
   logic [CH_W-1:0]                pick;
   logic [CH_W-1:0]                idx;

   assign elig = bus.metadata_request & ~avail_q;

   // First eligible channel searching upward from last+1, wrapping at N_CH-1.
   always_comb begin
      pick_vld = 1'b0;
      pick     = '0;
      idx      = '0;
      for (int k = 1; k <= int'(N_CH); k++) begin
         idx = CH_W'((int'(last_q) + k) % int'(N_CH));
         if (!pick_vld && elig[idx]) begin
            pick_vld = 1'b1;
            pick     = idx;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      ptr_d      = ptr_q;
      link_d     = link_q;
      avail_d    = avail_q & bus.metadata_request;
      mem_rd_d   = 1'b0;
      mem_addr_d = mem_addr_q;

      case (state_q)
         StIdle: begin
            if (!pause && pick_vld) begin
               grant_d    = pick;
               mem_rd_d   = 1'b1;
               mem_addr_d = {pick, ptr_q[pick]};
               state_d    = StIssue;
            end
         end
         StIssue: begin
            cnt_d   = CW'(RD_LAT - 1);
            state_d = (RD_LAT == 1) ? StCapture : StWait;
         end
         StWait: begin
            // Leaving as the count reaches zero lands CAPTURE on the data-valid cycle.
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) state_d = StCapture;
         end
         StCapture: begin
            link_d[grant_q]  = bus.mem_rdata;
            ptr_d[grant_q]   = ptr_q[grant_q] + 1'b1;
            last_d           = grant_q;
            avail_d[grant_q] = bus.metadata_request[grant_q];
            state_d          = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Abandons any in-flight read; link contents survive.
      if (restart) begin
         ptr_d      = '0;
         avail_d    = '0;
         last_d     = CH_W'(N_CH - 1);
         link_d     = link_q;
         mem_rd_d   = 1'b0;
         mem_addr_d = mem_addr_q;
         state_d    = StIdle;
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         grant_q    <= '0;
         last_q     <= CH_W'(N_CH - 1);
         cnt_q      <= '0;
         ptr_q      <= '0;
         link_q     <= '0;
         avail_q    <= '0;
         mem_rd_q   <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         link_q     <= link_d;
         avail_q    <= avail_d;
         mem_rd_q   <= mem_rd_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.metadata_available = avail_q;
   assign bus.metadata_link      = link_q;
   assign bus.mem_rd             = mem_rd_q;
   assign bus.mem_addr           = mem_addr_q;
   assign busy                   = busy_q;
endmodule

// File: tb/tb_metadata_arbiter.sv
// Randomised bench for metadata_arbiter against a fetch-timeline reference model
// with a behavioural fixed-latency memory.
module tb_metadata_arbiter;
   localparam int N_CH   = 37;
   localparam int DATA_W = 16;
   localparam int PTR_W  = 6;
   localparam int CH_W   = 6;
   localparam int RD_LAT = 2;
   localparam int AW     = CH_W + PTR_W;
   localparam int DEPTH  = 1 << AW;

   logic clk = 1'b0;
   logic reset_n;
   logic pause;
   logic restart;
   logic busy;
   logic [N_CH-1:0] req;

   metadata_arbiter_if #(.N_CH(N_CH), .DATA_W(DATA_W), .PTR_W(PTR_W), .CH_W(CH_W)) bus ();

   metadata_arbiter #(
      .N_CH(N_CH), .DATA_W(DATA_W), .PTR_W(PTR_W), .CH_W(CH_W), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .pause(pause),
      .restart(restart),
      .busy(busy),
      .bus(bus)
   );

   always #5 clk = ~clk;
   assign bus.metadata_request = req;

   logic [DATA_W-1:0] mem [DEPTH];
   bit                pv [RD_LAT+1];
   int                pa [RD_LAT+1];
   logic [DATA_W-1:0] rdata;
   assign bus.mem_rdata = rdata;

   int n_checks = 0;
   int n_fail   = 0;
   bit prev_rd  = 1'b0;

   // Reference model: one fetch is a timeline of RD_LAT+2 cycles from grant to idle.
   int                     m_ptr [N_CH];
   logic [N_CH-1:0]        m_avail;
   logic [N_CH*DATA_W-1:0] m_link;
   int                     m_last, m_fetch, m_age, m_faddr, m_addr;
   bit                     m_rd;

   task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_soft_reset();
      for (int i = 0; i < N_CH; i++) m_ptr[i] = 0;
      m_avail = '0;
      m_last  = N_CH - 1;
      m_fetch = -1;
      m_age   = 0;
      m_rd    = 1'b0;
   endtask

   task automatic model_step();
      logic [N_CH-1:0] avail_pre;
      if (!reset_n) begin
         model_soft_reset();
         m_link = '0;
         m_addr = 0;
      end else if (restart) begin
         model_soft_reset();
      end else begin
         avail_pre = m_avail;
         m_avail   = m_avail & req;
         m_rd      = 1'b0;
         if (m_fetch >= 0) begin
            if (m_age == 1 + RD_LAT) begin
               m_link[m_fetch*DATA_W +: DATA_W] = mem[m_faddr];
               m_ptr[m_fetch]   = (m_ptr[m_fetch] + 1) % (1 << PTR_W);
               m_last           = m_fetch;
               m_avail[m_fetch] = req[m_fetch];
               m_fetch          = -1;
            end else begin
               m_age++;
            end
         end else if (!pause) begin
            for (int k = 1; k <= N_CH; k++) begin
               int c;
               c = (m_last + k) % N_CH;
               if (req[c] && !avail_pre[c]) begin
                  m_fetch = c;
                  m_age   = 1;
                  m_faddr = c * (1 << PTR_W) + m_ptr[c];
                  m_addr  = m_faddr;
                  m_rd    = 1'b1;
                  break;
               end
            end
         end
      end
   endtask

   task automatic compare();
      chk("mem_rd", bus.mem_rd, m_rd);
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("available", bus.metadata_available, m_avail);
      chk("link", bus.metadata_link, m_link);
      chk("busy", busy, (m_fetch >= 0));
      chk("rd_back_to_back", bus.mem_rd & prev_rd, 1'b0);
      prev_rd = bus.mem_rd;
   endtask

   // Fixed-latency memory; outside the valid cycle the data bus carries junk.
   task automatic mem_step();
      for (int k = RD_LAT; k >= 1; k--) begin
         pv[k] = pv[k-1];
         pa[k] = pa[k-1];
      end
      pv[0] = bus.mem_rd;
      pa[0] = int'(bus.mem_addr);
      rdata = pv[RD_LAT] ? mem[pa[RD_LAT]] : DATA_W'($urandom);
   endtask

   task automatic cycle();
      @(negedge clk);
      model_step();
      compare();
      mem_step();
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'($urandom);
      for (int k = 0; k <= RD_LAT; k++) begin
         pv[k] = 1'b0;
         pa[k] = 0;
      end
      rdata   = '0;
      pause   = 1'b0;
      restart = 1'b0;
      reset_n = 1'b0;
      req     = '0;
      req[0]  = 1'b1;
      req[5]  = 1'b1;
      req[36] = 1'b1;
      model_soft_reset();
      m_link = '0;
      m_addr = 0;

      // Reset held with requests active, then round-robin among 0, 5, 36.
      repeat (3) cycle();
      reset_n = 1'b1;
      repeat (80) begin
         cycle();
         req[0]  = ~m_avail[0];
         req[5]  = ~m_avail[5];
         req[36] = ~m_avail[36];
      end

      // Randomised traffic on all channels with pause, restart and a mid-run reset.
      for (int cyc = 0; cyc < 20000; cyc++) begin
         cycle();
         for (int i = 0; i < N_CH; i++) begin
            if (req[i] && m_avail[i]) begin
               if ($urandom % 3 == 0) req[i] = 1'b0;
            end else if (!req[i]) begin
               if ($urandom % 8 == 0) req[i] = 1'b1;
            end else if ($urandom % 64 == 0) begin
               req[i] = 1'b0;
            end
         end
         if ($urandom % 50 == 0) pause = ~pause;
         restart = ($urandom % 300 == 0);
         if (cyc == 10000) reset_n = 1'b0;
         if (cyc == 10003) reset_n = 1'b1;
      end

      restart = 1'b0;
      pause   = 1'b0;
      repeat (10) cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
